// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game timer: FSM state encoding,
// seven-segment patterns and elaboration-time BCD helpers.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Active-low cathodes, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Shift-and-add-3 conversion, so no divider is needed even at elaboration
    function automatic logic [31:0] to_bcd(input logic [31:0] bin);
        logic [31:0] bcd;
        bcd = '0;
        for (int i = 31; i >= 0; i--) begin
            for (int d = 0; d < 8; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[30:0], bin[i]};
        end
        return bcd;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/game_timer_display_seg7_scan.sv
// Multiplexed seven-segment scanner: walks the digits from most to least
// significant, one digit per refresh period, with optional leading-zero blanking.
module seg7_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_LZ     = 1
) (
    input  logic                      clock_100Mhz,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value_bcd,
    output logic [NUM_DIGITS-1:0]     Anode_Activate,
    output logic [6:0]                LED_out
);
    import game_timer_pkg::*;

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] SCAN_LAST = IW'(NUM_DIGITS - 1);

    logic [REFRESH_BITS-1:0] r_refresh;
    logic [IW-1:0]           r_scan;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_led;

    logic [IW-1:0]           w_pos;
    logic [3:0]              w_digit;
    logic [NUM_DIGITS:0]     w_lz;
    logic [NUM_DIGITS-1:0]   w_anode;
    logic                    w_blank;

    // Scan index 0 maps to the leftmost digit
    assign w_pos   = SCAN_LAST - r_scan;
    assign w_digit = value_bcd[4*w_pos +: 4];

    // w_lz[k] is high when digit k and every digit above it are zero
    assign w_lz[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_scan
        assign w_lz[gi]    = (value_bcd[4*gi +: 4] == 4'd0) && w_lz[gi+1];
        assign w_anode[gi] = (w_pos != IW'(gi));
    end

    assign w_blank = (BLANK_LZ != 0) && (w_pos != '0) && w_lz[w_pos];

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_scan    <= '0;
            r_anode   <= '1;
            r_led     <= SEG_BLANK;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            if (&r_refresh) begin
                r_scan <= (r_scan == SCAN_LAST) ? '0 : r_scan + 1'b1;
            end
            r_anode <= w_blank ? '1 : w_anode;
            r_led   <= w_blank ? SEG_BLANK : seg_decode(w_digit);
        end
    end

    assign Anode_Activate = r_anode;
    assign LED_out        = r_led;

endmodule

// File: rtl/game_timer_display.sv
// BCD game timer: start/pause/clear FSM, prescaled tick, BCD step up/down
// with saturation at the terminal value, and a multiplexed display driver.
module game_timer_display #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1,
    parameter int NUM_DIGITS   = 4,
    parameter int STEP         = 2,
    parameter int LIMIT        = 30,
    parameter int COUNT_DOWN   = 0,
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_LZ     = 1
) (
    input  logic                      clock_100Mhz,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      clear,
    output logic                      running,
    output logic                      expired,
    output logic                      expired_pulse,
    output logic [4*NUM_DIGITS-1:0]   value_bcd,
    output logic [NUM_DIGITS-1:0]     Anode_Activate,
    output logic [6:0]                LED_out
);
    import game_timer_pkg::*;

    localparam int W  = 4 * NUM_DIGITS;
    localparam int P  = CLK_HZ / TICK_HZ;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] P_LAST      = PW'(P - 1);
    localparam logic [31:0]   LIMIT_BCD32 = to_bcd(32'(LIMIT));
    localparam logic [W-1:0]  LIMIT_BCD   = LIMIT_BCD32[W-1:0];
    localparam logic [W-1:0]  INIT_BCD    = (COUNT_DOWN != 0) ? LIMIT_BCD : '0;
    localparam logic [3:0]    STEP_BCD    = 4'(STEP);

    state_e          r_state;
    logic [W-1:0]    r_value;
    logic [PW-1:0]   r_presc;
    logic            r_expired_pulse;

    logic            w_tick;
    logic            w_pause_go;
    logic [NUM_DIGITS:0] w_carry;
    logic [NUM_DIGITS:0] w_borrow;
    logic [W-1:0]    w_sum_bcd;
    logic [W-1:0]    w_diff_bcd;
    logic            w_up_hit;
    logic            w_dn_hit;
    logic            w_hit;
    logic [W-1:0]    w_next_value;

    // Ripple BCD adder and subtractor; only digit 0 sees the step operand
    assign w_carry[0]  = 1'b0;
    assign w_borrow[0] = 1'b0;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        localparam logic [3:0] OPND = (gi == 0) ? STEP_BCD : 4'd0;
        logic [3:0] w_d;
        logic [4:0] w_sum5;
        logic [4:0] w_need5;
        logic [4:0] w_diff5;

        assign w_d       = r_value[4*gi +: 4];
        assign w_sum5    = {1'b0, w_d} + {1'b0, OPND} + {4'b0, w_carry[gi]};
        assign w_carry[gi+1] = (w_sum5 > 5'd9);
        // Adding 6 modulo 16 is the same as subtracting 10 for sums 10..19
        assign w_sum_bcd[4*gi +: 4] = w_carry[gi+1] ? (w_sum5[3:0] + 4'd6) : w_sum5[3:0];

        assign w_need5   = {1'b0, OPND} + {4'b0, w_borrow[gi]};
        assign w_borrow[gi+1] = ({1'b0, w_d} < w_need5);
        assign w_diff5   = {1'b0, w_d} - w_need5 + (w_borrow[gi+1] ? 5'd10 : 5'd0);
        assign w_diff_bcd[4*gi +: 4] = w_diff5[3:0];
    end

    // BCD ordering matches binary ordering, so a plain compare is valid
    assign w_up_hit = w_carry[NUM_DIGITS] || (w_sum_bcd >= LIMIT_BCD);
    assign w_dn_hit = w_borrow[NUM_DIGITS] || (w_diff_bcd == '0);
    assign w_hit    = (COUNT_DOWN != 0) ? w_dn_hit : w_up_hit;
    assign w_next_value = (COUNT_DOWN != 0) ? (w_dn_hit ? '0 : w_diff_bcd)
                                            : (w_up_hit ? LIMIT_BCD : w_sum_bcd);

    assign w_tick     = (r_state == ST_RUN) && (r_presc == P_LAST);
    assign w_pause_go = pause && !start;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_value         <= INIT_BCD;
            r_presc         <= '0;
            r_expired_pulse <= 1'b0;
        end else begin
            r_expired_pulse <= 1'b0;
            if (clear) begin
                r_state <= ST_IDLE;
                r_value <= INIT_BCD;
                r_presc <= '0;
            end else if (start && (r_state != ST_RUN)) begin
                r_state <= ST_RUN;
                // Resuming from PAUSED keeps the partial period
                if (r_state != ST_PAUSED) begin
                    r_presc <= '0;
                end
                if (r_state == ST_DONE) begin
                    r_value <= INIT_BCD;
                end
            end else if (r_state == ST_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_value <= w_next_value;
                    if (w_hit) begin
                        r_state         <= ST_DONE;
                        r_expired_pulse <= 1'b1;
                    end else if (w_pause_go) begin
                        r_state <= ST_PAUSED;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                    if (w_pause_go) begin
                        r_state <= ST_PAUSED;
                    end
                end
            end
        end
    end

    assign running       = (r_state == ST_RUN);
    assign expired       = (r_state == ST_DONE);
    assign expired_pulse = r_expired_pulse;
    assign value_bcd     = r_value;

    seg7_scan #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_BITS (REFRESH_BITS),
        .BLANK_LZ     (BLANK_LZ)
    ) u_scan (
        .clock_100Mhz   (clock_100Mhz),
        .reset          (reset),
        .value_bcd      (r_value),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out)
    );

endmodule
